// File: rtl/therm_ramp_ctrl.sv
// Level ramp controller: steps a 0..7 level toward a requested target one step per tick, holds HOLD_TICKS ticks, pulses done.
// Accept takes effect on the next edge; requests are refused (req_ready low) for the whole ramp/hold operation.
module therm_ramp_ctrl #(
   parameter int HOLD_TICKS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_target,
   input  logic       tick,
   input  logic       gray_en,
   output logic [2:0] level,
   output logic [6:0] therm,
   output logic [2:0] gray,
   output logic       busy,
   output logic       done
);

   localparam int CW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RAMP_UP,
      RAMP_DOWN,
      HOLD
   } state_t;

   state_t          state, state_n;
   logic [2:0]      level_n;
   logic [2:0]      target_r, target_n;
   logic [CW-1:0]   hold_cnt, hold_n;
   logic            done_n;
   logic [2:0]      level_inc, level_dec;

   assign level_inc = level + 3'd1;
   assign level_dec = level - 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         level    <= 3'd0;
         target_r <= 3'd0;
         hold_cnt <= '0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         level    <= level_n;
         target_r <= target_n;
         hold_cnt <= hold_n;
         done     <= done_n;
      end
   end

   always_comb begin
      state_n  = state;
      level_n  = level;
      target_n = target_r;
      hold_n   = hold_cnt;
      done_n   = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               target_n = req_target;
               hold_n   = '0;
               if (req_target > level)
                  state_n = RAMP_UP;
               else if (req_target < level)
                  state_n = RAMP_DOWN;
               else
                  state_n = HOLD;
            end
         end
         RAMP_UP: begin
            if (tick) begin
               // level < target_r <= 7 guarantees the increment cannot wrap
               if (level < target_r) begin
                  level_n = level_inc;
                  if (level_inc == target_r) begin
                     state_n = HOLD;
                     hold_n  = '0;
                  end
               end else begin
                  state_n = HOLD;
                  hold_n  = '0;
               end
            end
         end
         RAMP_DOWN: begin
            if (tick) begin
               if (level > target_r) begin
                  level_n = level_dec;
                  if (level_dec == target_r) begin
                     state_n = HOLD;
                     hold_n  = '0;
                  end
               end else begin
                  state_n = HOLD;
                  hold_n  = '0;
               end
            end
         end
         HOLD: begin
            if (tick) begin
               if (hold_cnt == HOLD_LAST) begin
                  state_n = IDLE;
                  hold_n  = '0;
                  done_n  = 1'b1;
               end else begin
                  hold_n = hold_cnt + CW'(1);
               end
            end
         end
         default: begin
            state_n = IDLE;
            hold_n  = '0;
         end
      endcase
   end

   assign req_ready = (state == IDLE);
   assign busy      = ~req_ready;

   always_comb begin
      therm = '0;
      for (int i = 0; i < 7; i++)
         therm[i] = (3'(i) < level);
   end

   assign gray = gray_en ? (level ^ (level >> 1)) : 3'b000;

endmodule
